// File: rtl/s420_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : s420_pkg
//  Purpose  : Shared types and constants for the s420 compare-word loader.
//  Revision : 1.0 - initial release
// ============================================================================
package s420_pkg;

    // Compare word width of the s420 counter/compare stage.
    localparam int unsigned S420_WORD_W = 17;

    // Byte lanes of the compare word, transferred LSB-first.
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned LANE0_LSB = 0;
    localparam int unsigned LANE1_LSB = 8;
    localparam int unsigned LANE2_BIT = 16;

    // Loader FSM: collecting byte 0/1/2, then waiting for a step-free commit.
    typedef enum logic [1:0] {
        ST_B0   = 2'd0,
        ST_B1   = 2'd1,
        ST_B2   = 2'd2,
        ST_PEND = 2'd3
    } ld_state_t;

endpackage : s420_pkg
`default_nettype wire

// File: rtl/s420_step_gen.sv
`default_nettype none
// ============================================================================
//  Module   : s420_step_gen
//  Purpose  : Programmable prescaler producing the registered P_0 step strobe
//             and the look-ahead step_next used to block commits.
//  Revision : 1.0 - initial release
// ============================================================================
module s420_step_gen #(
    parameter int DIV_W = 4
) (
    input  logic             ck_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             step_next_o,
    output logic             p0_o
);

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             step_next;
    logic             p0_q;

    // Next count: wrap on a step (also covers DIV lowered below cnt), hold when idle.
    always_comb begin
        step_next = run_i && (cnt_q >= div_i);
        cnt_d     = cnt_q;
        if (run_i) begin
            cnt_d = step_next ? '0 : (cnt_q + CNT_ONE);
        end
    end

    // Prescaler count and registered step strobe.
    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            p0_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            p0_q  <= step_next;
        end
    end

    assign step_next_o = step_next;
    assign p0_o        = p0_q;

endmodule : s420_step_gen
`default_nettype wire

// File: rtl/s420_cword_loader.sv
`default_nettype none
// ============================================================================
//  Module   : s420_cword_loader
//  Purpose  : Collects a 17-bit compare word from three byte transfers into a
//             shadow register and commits it to C only on a cycle with no
//             count step, so the compare never sees a torn word at a step.
//  Revision : 1.0 - initial release
// ============================================================================
module s420_cword_loader
    import s420_pkg::*;
#(
    parameter int DIV_W  = 4,
    parameter int WORD_W = S420_WORD_W
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              RUN,
    input  logic [DIV_W-1:0]  DIV,
    input  logic              LD_VALID,
    input  logic              LD_FIRST,
    input  logic [7:0]        LD_DATA,
    output logic              LD_READY,
    output logic [WORD_W-1:0] C,
    output logic              P_0,
    output logic              CFG_PEND,
    output logic [7:0]        WORDS_CNT
);

    ld_state_t         state_q;
    ld_state_t         state_d;
    logic [WORD_W-1:0] shadow_q;
    logic [WORD_W-1:0] shadow_d;
    logic [WORD_W-1:0] c_q;
    logic [WORD_W-1:0] c_d;
    logic [7:0]        words_q;
    logic [7:0]        words_d;

    logic w_step_next;
    logic w_accept;
    logic w_commit;
    logic w_unused;

    // Upper bits of byte 2 carry no information for a 17-bit word.
    assign w_unused = ^LD_DATA[7:1];

    s420_step_gen #(
        .DIV_W (DIV_W)
    ) u_step_gen (
        .ck_i        (CK),
        .rst_i       (RST),
        .run_i       (RUN),
        .div_i       (DIV),
        .step_next_o (w_step_next),
        .p0_o        (P_0)
    );

    assign LD_READY = (state_q != ST_PEND);
    assign CFG_PEND = (state_q == ST_PEND);
    assign w_accept = LD_VALID && LD_READY;
    assign w_commit = (state_q == ST_PEND) && !w_step_next;

    // Loader FSM next state, shadow byte-lane loads and step-free commit.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        c_d      = c_q;
        words_d  = words_q;
        case (state_q)
            ST_B0: begin
                if (w_accept) begin
                    shadow_d[LANE0_LSB +: BYTE_W] = LD_DATA;
                    state_d                       = ST_B1;
                end
            end
            ST_B1: begin
                if (w_accept) begin
                    if (LD_FIRST) begin
                        shadow_d[LANE0_LSB +: BYTE_W] = LD_DATA;
                        state_d                       = ST_B1;
                    end else begin
                        shadow_d[LANE1_LSB +: BYTE_W] = LD_DATA;
                        state_d                       = ST_B2;
                    end
                end
            end
            ST_B2: begin
                if (w_accept) begin
                    if (LD_FIRST) begin
                        shadow_d[LANE0_LSB +: BYTE_W] = LD_DATA;
                        state_d                       = ST_B1;
                    end else begin
                        shadow_d[LANE2_BIT] = LD_DATA[0];
                        state_d             = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (w_commit) begin
                    c_d     = shadow_q;
                    words_d = words_q + 8'd1;
                    state_d = ST_B0;
                end
            end
            default: begin
                state_d = ST_B0;
            end
        endcase
    end

    // State, shadow, active word and commit counter registers.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_B0;
            shadow_q <= '0;
            c_q      <= '0;
            words_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            c_q      <= c_d;
            words_q  <= words_d;
        end
    end

    assign C         = c_q;
    assign WORDS_CNT = words_q;

endmodule : s420_cword_loader
`default_nettype wire

// File: doc/s420_cword_loader.md
# s420_cword_loader

Upstream feeder for the s420 counter/compare stage. Accepts a 17-bit compare word as three byte transfers over a valid/ready port and holds it in a shadow register. It commits the word to the C_16..C_0 outputs only on a cycle where no count step is being issued, so the downstream compare never sees a half-updated word around a step. It also generates the P_0 count-step strobe from a programmable prescaler.

## Interface
Parameters:
- DIV_W, 4: prescaler divide-field width.
- WORD_W, 17: compare word width. Fixed at 17 for s420. Other values are unsupported.

Ports:
- CK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- RUN  in  1  enables P_0 step generation.
- DIV  in  DIV_W  step period minus one; quasi-static.
- LD_VALID  in  1  byte transfer valid.
- LD_FIRST  in  1  marks byte 0 of a word; qualified by LD_VALID.
- LD_DATA  in  8  byte payload.
- LD_READY  out  1  loader can accept a byte.
- C  out  WORD_W  active compare word; bit k drives downstream C_k.
- P_0  out  1  count-step strobe, registered, one cycle wide.
- CFG_PEND  out  1  a full word is waiting for commit.
- WORDS_CNT  out  8  number of committed words, wraps modulo 256.

## Operation
- Transfer: a byte is accepted on a CK edge when LD_VALID && LD_READY && !RST.
- LD_READY = (state != PEND).
- Byte order is LSB-first:
  - byte0 goes to shadow[7:0];
  - byte1 goes to shadow[15:8];
  - byte2 bit0 goes to shadow[16]; byte2 bits [7:1] are ignored.
- Loader FSM states: B0, B1, B2, PEND.
  - B0: an accepted byte loads as byte0, then the FSM moves to B1. LD_FIRST is not required in this state.
  - B1 or B2 with an accepted byte and LD_FIRST=1: the FSM resynchronises. The byte loads as byte0 and the FSM moves to B1. The partial word is discarded.
  - B1 with an accepted byte and LD_FIRST=0: the byte loads as byte1, then the FSM moves to B2.
  - B2 with an accepted byte and LD_FIRST=0: the byte loads as byte2, then the FSM moves to PEND.
  - PEND: no bytes are accepted. The FSM stays until commit.
- Prescaler: 4-bit cnt.
  - step_next = RUN && (cnt >= DIV).
  - When RUN=1: cnt <= step_next ? 0 : cnt+1.
  - When RUN=0: cnt holds.
  - P_0 <= step_next.
- Commit happens when state == PEND && !step_next. On that edge:
  - C <= shadow;
  - WORDS_CNT increments;
  - the FSM moves to B0.
- CFG_PEND = (state == PEND).

## Timing
- Reset values:
  - C = 0, P_0 = 0, cnt = 0, WORDS_CNT = 0;
  - state = B0, so CFG_PEND = 0 and LD_READY = 1;
  - no byte is accepted while RST is high.
- Reset mid-word or in PEND: the shadow word is discarded and C returns to 0 asynchronously.
- Step period:
  - RUN=1 and DIV=d gives one P_0 pulse every d+1 cycles. The first pulse follows d+1 edges after RUN rises from cnt=0.
  - DIV=0 gives P_0 high continuously.
- When DIV is lowered below cnt, the next edge with RUN=1 pulses P_0 and wraps cnt to 0.
- Load latency:
  - The byte2 accept edge enters PEND.
  - The earliest commit is the next edge, so C updates 2 edges after byte2 is presented, given ready.
- C never changes on an edge where P_0 becomes 1.
- With RUN=1 and DIV=0, commit stalls until RUN=0. LD_READY stays 0 for the whole stall.
- Simultaneous events:
  - Commit and an LD_VALID on the same edge: the byte is not accepted, because LD_READY was 0 in PEND. It is accepted on the next edge in B0.
  - RUN deasserted in PEND: commit occurs on the next edge.

## Structure
- Shared package s420_pkg holds:
  - the loader state enum {B0, B1, B2, PEND};
  - the WORD_W constant;
  - byte-lane index constants.
- Sub-module s420_step_gen contains the prescaler and the P_0 register. It exports step_next to the loader FSM.
- Top level contains the FSM, the shadow register, C and WORDS_CNT.

## Test plan
- Reset, then RUN=1 and DIV=3 with no loads:
  - P_0 pulses on edges 4, 8, 12;
  - C stays 0x00000.
- RUN=0, bytes 0xA5, 0x3C, 0x01 with LD_FIRST on byte0:
  - CFG_PEND rises after byte2;
  - C=0x13CA5 one edge later;
  - WORDS_CNT=1.
- RUN=1, DIV=0, load a word:
  - LD_READY=0 and CFG_PEND=1 hold indefinitely;
  - dropping RUN gives the commit on the next edge.
- In B2, present LD_FIRST with 0x11, then 0x22, then 0x00:
  - C=0x02211;
  - the earlier partial word is discarded.
- DIV=2 with the load completing so that step_next=1 in PEND:
  - commit is delayed one edge;
  - C never changes on an edge where P_0 becomes 1.
- Assert RST asynchronously while in PEND with C=0x1FFFF:
  - C, P_0 and CFG_PEND drop immediately;
  - after release, the FSM is in B0 and LD_READY=1.
